// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time for a bounded
// burst and gates every FIFO write on the full flag.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  active_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              accept;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int unsigned       idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Scan from last_owner+1 with wrap; the first hit wins, later hits are ignored.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_owner_q) + off) % NUM_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d      = pick_id;
          last_owner_d = pick_id;
          beat_cnt_d   = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if ((accept && beat_cnt_q == CNT_W'(MAX_BURST - 1)) || !req[owner_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt          = '0;
    accept       = 1'b0;
    fifo_wr      = 1'b0;
    fifo_data_in = '0;
    if (state_q == BURST) begin
      gnt[owner_q] = ~fifo_full;
      accept       = req[owner_q] & ~fifo_full;
      fifo_wr      = accept;
      if (accept) fifo_data_in = req_data[owner_q*DATA_W +: DATA_W];
    end
    busy      = (state_q == BURST);
    active_id = owner_q;
  end

endmodule
